// File: rtl/comparer.sv
// Registered compare back-end for the ALU subtract path.
// Turns ALU flags into eql/slt/sltu plus an advisory flag-consistency bit.
module comparer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] result,
    input  logic             cout,
    input  logic             zero,
    input  logic             sign,
    input  logic             overflow,
    output logic             out_valid,
    output logic             eql,
    output logic             slt,
    output logic             sltu,
    output logic             flag_err
);

    typedef struct packed {
        logic eql;
        logic slt;
        logic sltu;
        logic flag_err;
    } cmp_t;

    cmp_t nxt;
    cmp_t q;
    logic vq;
    logic res_zero;

    assign res_zero = (result == '0);

    always_comb begin
        nxt          = '0;
        nxt.eql      = zero;
        nxt.slt      = sign ^ overflow;
        nxt.sltu     = ~cout;
        nxt.flag_err = (zero != res_zero) | (sign != result[WIDTH-1]);
    end

    // Results hold across idle cycles; only out_valid tracks every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vq <= 1'b0;
            q  <= '0;
        end else begin
            vq <= in_valid;
            if (in_valid) begin
                q <= nxt;
            end
        end
    end

    assign out_valid = vq;
    assign eql       = q.eql;
    assign slt       = q.slt;
    assign sltu      = q.sltu;
    assign flag_err  = q.flag_err;

    // Operands ride along for width checking only.
    logic unused_ab;
    assign unused_ab = ^{a, b};

endmodule

// File: tb/tb_comparer.sv
// Randomized bench for comparer at WIDTH=8 and WIDTH=1.
// Reference model derives expectations from the flag rules directly.
module tb_comparer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, res8 = '0;
    logic       a1 = 1'b0, b1 = 1'b0, res1 = 1'b0;
    logic       cout = 1'b0, zero = 1'b0, sign = 1'b0, overflow = 1'b0;

    logic ov8, eq8, lt8, ltu8, er8;
    logic ov1, eq1, lt1, ltu1, er1;

    int ncmp = 0;
    int nerr = 0;

    typedef struct {
        logic ov;
        logic eq;
        logic lt;
        logic ltu;
        logic er;
    } exp_t;

    exp_t m8, m1;

    always #5 clk = ~clk;

    comparer #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a8), .b(b8), .result(res8),
        .cout(cout), .zero(zero), .sign(sign), .overflow(overflow),
        .out_valid(ov8), .eql(eq8), .slt(lt8), .sltu(ltu8), .flag_err(er8)
    );

    comparer #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a1), .b(b1), .result(res1),
        .cout(cout), .zero(zero), .sign(sign), .overflow(overflow),
        .out_valid(ov1), .eql(eq1), .slt(lt1), .sltu(ltu1), .flag_err(er1)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        ncmp++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input exp_t prev, input logic [63:0] r, input int w);
        exp_t e;
        logic r_is_zero;
        logic msb;
        e = prev;
        e.ov = in_valid;
        if (in_valid) begin
            r_is_zero = ((r << (64 - w)) == 64'd0);
            msb = r[w-1];
            e.eq  = zero;
            e.lt  = (sign != overflow);
            e.ltu = !cout;
            e.er  = (zero != r_is_zero) || (sign != msb);
        end
        return e;
    endfunction

    task automatic check_all();
        chk("ov8", ov8, m8.ov);
        chk("eql8", eq8, m8.eq);
        chk("slt8", lt8, m8.lt);
        chk("sltu8", ltu8, m8.ltu);
        chk("err8", er8, m8.er);
        chk("ov1", ov1, m1.ov);
        chk("eql1", eq1, m1.eq);
        chk("slt1", lt1, m1.lt);
        chk("sltu1", ltu1, m1.ltu);
        chk("err1", er1, m1.er);
    endtask

    task automatic model_reset();
        m8 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        m1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            m8 = model(m8, {56'd0, res8}, 8);
            m1 = model(m1, {63'd0, res1}, 1);
        end
        #1;
        check_all();
    endtask

    task automatic set_flags(input logic v, input logic c, input logic z,
                             input logic s, input logic o);
        in_valid = v;
        cout = c;
        zero = z;
        sign = s;
        overflow = o;
    endtask

    // Flags an honest 8-bit ALU would produce for a8 - b8.
    task automatic real_alu8();
        logic [8:0] sum;
        sum = {1'b0, a8} + {1'b0, ~b8} + 9'd1;
        res8 = sum[7:0];
        cout = sum[8];
        zero = (sum[7:0] == 8'd0);
        sign = sum[7];
        overflow = (a8[7] != b8[7]) && (sum[7] != a8[7]);
    endtask

    initial begin
        model_reset();
        // Reset held while clocking valid inputs
        set_flags(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        res8 = 8'h00;
        res1 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all();
        end
        #2 rst_n = 1'b1;
        tick();
        chk("rst_rel_ov", ov8, 1'b1);
        chk("rst_rel_eq", eq8, 1'b1);

        // Width-1: zero disagrees with result==0
        #2 set_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        res1 = 1'b0;
        tick();
        chk("w1_sltu", ltu1, 1'b1);
        chk("w1_err", er1, 1'b1);

        // Overflow with clear sign means less-than
        #2 set_flags(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("ovf_slt", lt1, 1'b1);
        chk("ovf_sltu", ltu1, 1'b0);

        // Sign disagrees with result MSB, then agrees
        #2 set_flags(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        res1 = 1'b1;
        tick();
        chk("msb_err", er1, 1'b1);
        #2 sign = 1'b1;
        tick();
        chk("msb_slt", lt1, 1'b1);
        chk("msb_ok", er1, 1'b0);

        // Overflow with set sign means not less-than
        #2 set_flags(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        chk("ovf_sgn", lt1, 1'b0);

        // Width-8 equal case
        #2 set_flags(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        res8 = 8'h00;
        tick();
        chk("w8_eq", eq8, 1'b1);
        chk("w8_err", er8, 1'b0);

        // Impossible zero with borrow still follows the rules
        #2 set_flags(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("imp_eq", eq8, 1'b1);
        chk("imp_ltu", ltu8, 1'b1);

        // Hold: slt case then idle cycle with all flags low
        #2 set_flags(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        #2 set_flags(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("hold_slt", lt8, 1'b1);
        chk("hold_ov", ov8, 1'b0);

        // Randomized traffic with occasional mid-stream reset
        for (int i = 0; i < 400; i++) begin
            #2;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) begin
                real_alu8();
            end else begin
                res8 = 8'($urandom);
                {cout, zero, sign, overflow} = 4'($urandom);
            end
            a1 = a8[0];
            b1 = b8[0];
            res1 = 1'($urandom);
            tick();
            if ($urandom_range(0, 39) == 0) begin
                #1 rst_n = 1'b0;
                model_reset();
                #1;
                check_all();
                #1 rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
